// File: rtl/cc_level_lives_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_level_lives_pkg
// Description : Shared state encoding for the Frogger level/lives tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_level_lives_pkg;

    localparam int STATE_DATAWIDTH = 3;

    typedef enum logic [STATE_DATAWIDTH-1:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cc_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : cc_rise_detect
// Description : Single-bit rising-edge detector. The event is formed from the
//               current input and a one-cycle history register, so a held
//               input yields exactly one event on the first sampling edge.
// Ports       : clk, rst (async, active-high), i_sig (level in),
//               o_rise (combinational edge event)
// Revision    : 1.0 - initial release
// ============================================================================
module cc_rise_detect #(
    parameter logic RESET_VALUE = 1'b0   // history value = inactive input level
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= RESET_VALUE;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/cc_level_lives_tracker.sv
`default_nettype none
// ============================================================================
// Module      : cc_level_lives_tracker
// Description : Level and lives manager for Frogger. Counts cleared levels up
//               to MAX_LEVEL, counts lives down on collisions, inserts a
//               PAUSE_CYCLES pause between levels and flags max-level,
//               game-over and win.
// Ports       : CLOCK_50 / RESET_InHigh (async)  - clock and reset
//               start_InLow, goal_InHigh, hit_InHigh - event inputs
//               level_OutBUS, lives_OutBUS          - counters
//               levelmax_OutLow, pause_OutHigh,
//               gameover_OutLow, win_OutHigh        - registered status flags
// Revision    : 1.0 - initial release
// ============================================================================
module cc_level_lives_tracker
    import cc_level_lives_pkg::*;
#(
    parameter int LEVELS_DATAWIDTH = 2,
    parameter int MAX_LEVEL        = 3,
    parameter int LIVES_DATAWIDTH  = 2,
    parameter int INIT_LIVES       = 3,
    parameter int PAUSE_CYCLES     = 4,
    parameter int PAUSE_DATAWIDTH  = $clog2(PAUSE_CYCLES + 1)
) (
    input  logic                        CC_LEVEL_LIVES_TRACKER_CLOCK_50,
    input  logic                        CC_LEVEL_LIVES_TRACKER_RESET_InHigh,
    input  logic                        CC_LEVEL_LIVES_TRACKER_start_InLow,
    input  logic                        CC_LEVEL_LIVES_TRACKER_goal_InHigh,
    input  logic                        CC_LEVEL_LIVES_TRACKER_hit_InHigh,
    output logic [LEVELS_DATAWIDTH-1:0] CC_LEVEL_LIVES_TRACKER_level_OutBUS,
    output logic [LIVES_DATAWIDTH-1:0]  CC_LEVEL_LIVES_TRACKER_lives_OutBUS,
    output logic                        CC_LEVEL_LIVES_TRACKER_levelmax_OutLow,
    output logic                        CC_LEVEL_LIVES_TRACKER_pause_OutHigh,
    output logic                        CC_LEVEL_LIVES_TRACKER_gameover_OutLow,
    output logic                        CC_LEVEL_LIVES_TRACKER_win_OutHigh
);

    localparam logic [LEVELS_DATAWIDTH-1:0] c_MAX_LEVEL  = LEVELS_DATAWIDTH'(MAX_LEVEL);
    localparam logic [LEVELS_DATAWIDTH-1:0] c_LEVEL_ONE  = LEVELS_DATAWIDTH'(1);
    localparam logic [LIVES_DATAWIDTH-1:0]  c_INIT_LIVES = LIVES_DATAWIDTH'(INIT_LIVES);
    localparam logic [LIVES_DATAWIDTH-1:0]  c_ONE_LIFE   = LIVES_DATAWIDTH'(1);
    localparam logic [PAUSE_DATAWIDTH-1:0]  c_PAUSE_LOAD = PAUSE_DATAWIDTH'(PAUSE_CYCLES - 1);
    localparam logic [PAUSE_DATAWIDTH-1:0]  c_PAUSE_ONE  = PAUSE_DATAWIDTH'(1);

    logic clk;
    logic rst;
    assign clk = CC_LEVEL_LIVES_TRACKER_CLOCK_50;
    assign rst = CC_LEVEL_LIVES_TRACKER_RESET_InHigh;

    // ------------------------------------------------------------------
    // Event detection. The start button is active-low, so it is inverted
    // before the detector; its inactive (inverted) level is then 0.
    // ------------------------------------------------------------------
    logic w_start_ev;
    logic w_goal_ev;
    logic w_hit_ev;

    cc_rise_detect #(.RESET_VALUE(1'b0)) u_start_det (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (~CC_LEVEL_LIVES_TRACKER_start_InLow),
        .o_rise (w_start_ev)
    );

    cc_rise_detect #(.RESET_VALUE(1'b0)) u_goal_det (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (CC_LEVEL_LIVES_TRACKER_goal_InHigh),
        .o_rise (w_goal_ev)
    );

    cc_rise_detect #(.RESET_VALUE(1'b0)) u_hit_det (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (CC_LEVEL_LIVES_TRACKER_hit_InHigh),
        .o_rise (w_hit_ev)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t                      r_state;
    logic [LEVELS_DATAWIDTH-1:0] r_level;
    logic [LIVES_DATAWIDTH-1:0]  r_lives;
    logic [PAUSE_DATAWIDTH-1:0]  r_pause_cnt;
    logic                        r_levelmax_n;
    logic                        r_pause;
    logic                        r_gameover_n;
    logic                        r_win;

    state_t                      w_state_nxt;
    logic [LEVELS_DATAWIDTH-1:0] w_level_nxt;
    logic [LIVES_DATAWIDTH-1:0]  w_lives_nxt;
    logic [PAUSE_DATAWIDTH-1:0]  w_pause_cnt_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_level_nxt     = r_level;
        w_lives_nxt     = r_lives;
        w_pause_cnt_nxt = r_pause_cnt;
        case (r_state)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (w_start_ev) begin
                    w_level_nxt = '0;
                    w_lives_nxt = c_INIT_LIVES;
                    w_state_nxt = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                // A collision wins over reaching the goal in the same cycle.
                if (w_hit_ev) begin
                    if (r_lives == c_ONE_LIFE) begin
                        w_lives_nxt = '0;
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_lives_nxt = r_lives - c_ONE_LIFE;
                    end
                end else if (w_goal_ev) begin
                    // Checking the ceiling first keeps the level from wrapping.
                    if (r_level == c_MAX_LEVEL) begin
                        w_state_nxt = ST_WIN;
                    end else begin
                        w_level_nxt     = r_level + c_LEVEL_ONE;
                        w_pause_cnt_nxt = c_PAUSE_LOAD;
                        w_state_nxt     = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                // Loaded with PAUSE_CYCLES-1 and left at zero, so the pause
                // lasts exactly PAUSE_CYCLES cycles; events are dropped here.
                if (r_pause_cnt == '0) begin
                    w_state_nxt = ST_PLAYING;
                end else begin
                    w_pause_cnt_nxt = r_pause_cnt - c_PAUSE_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Flags are registered from the next-state values so they change on the
    // same edge as the state and counters they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_level      <= '0;
            r_lives      <= c_INIT_LIVES;
            r_pause_cnt  <= '0;
            r_levelmax_n <= (c_MAX_LEVEL != '0);
            r_pause      <= 1'b0;
            r_gameover_n <= 1'b1;
            r_win        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_lives      <= w_lives_nxt;
            r_pause_cnt  <= w_pause_cnt_nxt;
            r_levelmax_n <= (w_level_nxt != c_MAX_LEVEL);
            r_pause      <= (w_state_nxt == ST_PAUSE);
            r_gameover_n <= (w_state_nxt != ST_GAME_OVER);
            r_win        <= (w_state_nxt == ST_WIN);
        end
    end

    assign CC_LEVEL_LIVES_TRACKER_level_OutBUS    = r_level;
    assign CC_LEVEL_LIVES_TRACKER_lives_OutBUS    = r_lives;
    assign CC_LEVEL_LIVES_TRACKER_levelmax_OutLow = r_levelmax_n;
    assign CC_LEVEL_LIVES_TRACKER_pause_OutHigh   = r_pause;
    assign CC_LEVEL_LIVES_TRACKER_gameover_OutLow = r_gameover_n;
    assign CC_LEVEL_LIVES_TRACKER_win_OutHigh     = r_win;

endmodule
`default_nettype wire

// File: tb/tb_cc_level_lives_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_level_lives_tracker
// Description : Self-checking bench for cc_level_lives_tracker: directed
//               game scenarios with literal expectations, then randomized
//               play compared every cycle against a behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_level_lives_tracker;

    localparam int MAX_LEVEL    = 3;
    localparam int INIT_LIVES   = 3;
    localparam int PAUSE_CYCLES = 4;

    // Model modes (bench-local meaning only)
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER = 3;
    localparam int M_WIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_n = 1'b1;
    logic       goal = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] level;
    logic [1:0] lives;
    logic       levelmax_n;
    logic       pause;
    logic       gameover_n;
    logic       win;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    cc_level_lives_tracker dut (
        .CC_LEVEL_LIVES_TRACKER_CLOCK_50        (clk),
        .CC_LEVEL_LIVES_TRACKER_RESET_InHigh    (rst),
        .CC_LEVEL_LIVES_TRACKER_start_InLow     (start_n),
        .CC_LEVEL_LIVES_TRACKER_goal_InHigh     (goal),
        .CC_LEVEL_LIVES_TRACKER_hit_InHigh      (hit),
        .CC_LEVEL_LIVES_TRACKER_level_OutBUS    (level),
        .CC_LEVEL_LIVES_TRACKER_lives_OutBUS    (lives),
        .CC_LEVEL_LIVES_TRACKER_levelmax_OutLow (levelmax_n),
        .CC_LEVEL_LIVES_TRACKER_pause_OutHigh   (pause),
        .CC_LEVEL_LIVES_TRACKER_gameover_OutLow (gameover_n),
        .CC_LEVEL_LIVES_TRACKER_win_OutHigh     (win)
    );

    // ------------------------------------------------------------------
    // Behavioural game model
    // ------------------------------------------------------------------
    int   m_mode;
    int   m_level;
    int   m_lives;
    int   m_pause_left;   // pause cycles still to spend
    logic m_start_prev;
    logic m_goal_prev;
    logic m_hit_prev;
    logic m_ev_start;
    logic m_ev_goal;
    logic m_ev_hit;

    assign m_ev_start = m_start_prev & ~start_n;
    assign m_ev_goal  = goal & ~m_goal_prev;
    assign m_ev_hit   = hit & ~m_hit_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode       <= M_IDLE;
            m_level      <= 0;
            m_lives      <= INIT_LIVES;
            m_pause_left <= 0;
            m_start_prev <= 1'b1;
            m_goal_prev  <= 1'b0;
            m_hit_prev   <= 1'b0;
        end else begin
            m_start_prev <= start_n;
            m_goal_prev  <= goal;
            m_hit_prev   <= hit;
            if (m_mode == M_PLAY) begin
                if (m_ev_hit) begin
                    m_lives <= m_lives - 1;
                    if (m_lives - 1 == 0) m_mode <= M_OVER;
                end else if (m_ev_goal) begin
                    if (m_level >= MAX_LEVEL) begin
                        m_mode <= M_WIN;
                    end else begin
                        m_level      <= m_level + 1;
                        m_pause_left <= PAUSE_CYCLES;
                        m_mode       <= M_PAUSE;
                    end
                end
            end else if (m_mode == M_PAUSE) begin
                m_pause_left <= m_pause_left - 1;
                if (m_pause_left - 1 == 0) m_mode <= M_PLAY;
            end else if (m_ev_start) begin
                m_level <= 0;
                m_lives <= INIT_LIVES;
                m_mode  <= M_PLAY;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    task automatic cycle_check();
        int e_lvl, e_liv, e_lmx, e_pau, e_gon, e_win;
        e_lvl = m_level;
        e_liv = m_lives;
        e_lmx = (m_level != MAX_LEVEL) ? 1 : 0;
        e_pau = (m_mode == M_PAUSE) ? 1 : 0;
        e_gon = (m_mode != M_OVER) ? 1 : 0;
        e_win = (m_mode == M_WIN) ? 1 : 0;
        n_total++;
        if (int'(level) == e_lvl && int'(lives) == e_liv && int'(levelmax_n) == e_lmx &&
            int'(pause) == e_pau && int'(gameover_n) == e_gon && int'(win) == e_win) begin
            n_pass++;
        end else begin
            $display("FAIL cycle_model at %0t: got lvl=%0d liv=%0d lmx_n=%0b pau=%0b go_n=%0b win=%0b, expected lvl=%0d liv=%0d lmx_n=%0d pau=%0d go_n=%0d win=%0d",
                     $time, level, lives, levelmax_n, pause, gameover_n, win,
                     e_lvl, e_liv, e_lmx, e_pau, e_gon, e_win);
        end
    endtask

    // Stimulus helpers: inputs change just after the falling edge; reset
    // moves 2 time units later so it never coincides with a sample point.
    task automatic pulse(input int which);
        if (which == 0) start_n = 1'b0;
        else if (which == 1) goal = 1'b1;
        else hit = 1'b1;
        @(negedge clk);
        start_n = 1'b1;
        goal    = 1'b0;
        hit     = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input int lvl, input int liv,
                               input int lmx, input int pau, input int gon, input int wn);
        chk({tag, ".level"},      int'(level),      lvl);
        chk({tag, ".lives"},      int'(lives),      liv);
        chk({tag, ".levelmax_n"}, int'(levelmax_n), lmx);
        chk({tag, ".pause"},      int'(pause),      pau);
        chk({tag, ".gameover_n"}, int'(gameover_n), gon);
        chk({tag, ".win"},        int'(win),        wn);
    endtask

    initial begin
        int pause_cnt;
        int lvl_seen;
        int hit_rate;

        // Per-cycle model comparison runs alongside the stimulus.
        fork
            forever begin
                @(negedge clk);
                if (chk_en) cycle_check();
            end
        join_none

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check_flags("reset", 0, 3, 1, 0, 1, 0);

        // Start, then goal held for 10 cycles: one level step, 4-cycle pause.
        pulse(0);
        check_flags("started", 0, 3, 1, 0, 1, 0);
        goal = 1'b1;
        pause_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pause) pause_cnt++;
        end
        goal = 1'b0;
        lvl_seen = int'(level);
        chk("goal_hold.pause_cycles", pause_cnt, PAUSE_CYCLES);
        chk("goal_hold.level", lvl_seen, 1);
        @(negedge clk);
        chk("goal_hold.back_playing", int'(pause), 0);

        // Three hits: 3 -> 2 -> 1 -> 0 and game over.
        pulse(2);
        chk("hit1.lives", int'(lives), 2);
        pulse(2);
        chk("hit2.lives", int'(lives), 1);
        chk("hit2.gameover_n", int'(gameover_n), 1);
        pulse(2);
        check_flags("hit3", 1, 0, 1, 0, 0, 0);
        pulse(1);
        pulse(1);
        chk("gameover_goal.level", int'(level), 1);

        // Restart; simultaneous goal and hit with 2 lives.
        pulse(0);
        check_flags("restart", 0, 3, 1, 0, 1, 0);
        pulse(2);
        chk("pre_both.lives", int'(lives), 2);
        goal = 1'b1;
        hit  = 1'b1;
        @(negedge clk);
        goal = 1'b0;
        hit  = 1'b0;
        @(negedge clk);
        check_flags("goal_and_hit", 0, 1, 1, 0, 1, 0);

        // Lose the last life, restart, then climb to the win.
        pulse(2);
        chk("last_life.gameover_n", int'(gameover_n), 0);
        pulse(0);
        for (int g = 1; g <= 3; g++) begin
            pulse(1);
            chk("climb.pause", int'(pause), 1);
            chk("climb.level", int'(level), g);
            repeat (PAUSE_CYCLES) @(negedge clk);
            chk("climb.pause_done", int'(pause), 0);
        end
        chk("at_max.levelmax_n", int'(levelmax_n), 0);
        pulse(1);
        check_flags("win", 3, 3, 0, 0, 1, 1);

        // From WIN, start reloads the game.
        pulse(0);
        check_flags("win_restart", 0, 3, 1, 0, 1, 0);

        // Reset asserted mid-pause at level 2 acts immediately.
        pulse(1);
        repeat (PAUSE_CYCLES) @(negedge clk);
        pulse(1);
        chk("mid_pause.level", int'(level), 2);
        chk("mid_pause.pause", int'(pause), 1);
        #2 rst = 1'b1;
        #1;
        check_flags("async_reset", 0, 3, 1, 0, 1, 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Randomized play against the model.
        hit_rate = 8;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) hit_rate = ($urandom_range(0, 1) == 0) ? 0 : 8;
            start_n = ($urandom_range(0, 15) != 0);
            goal    = ($urandom_range(0, 4) == 0);
            hit     = (hit_rate != 0) && ($urandom_range(0, hit_rate - 1) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        start_n = 1'b1;
        goal    = 1'b0;
        hit     = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
